id_ex_stage_reg: RTL and testbench

//   ID/EX pipeline register with integrated load-use hazard detection and write-back bypass.

---
 rtl/id_ex_stage_reg_if.sv | 81 ++++++++
 rtl/id_ex_stage_reg.sv | 106 ++++++++++
 tb/tb_id_ex_stage_reg.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage register bus: ID-side operands and control in,
// registered EX-side fields, stall and bubble count out.
interface id_ex_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_uses_rt;
  logic [DATA_W-1:0] id_rd1;
  logic [DATA_W-1:0] id_rd2;
  logic [DATA_W-1:0] id_imm;
  logic              id_ctl_reg_write;
  logic              id_ctl_mem_read;
  logic              id_ctl_mem_write;
  logic              id_ctl_mem_to_reg;
  logic              id_ctl_alu_src;
  logic              id_ctl_reg_dst;
  logic [3:0]        id_ctl_alu_op;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic              ex_stall;
  logic              stall;
  logic              id_ex_valid;
  logic [REG_AW-1:0] id_ex_rs;
  logic [REG_AW-1:0] id_ex_rt;
  logic [REG_AW-1:0] id_ex_write_reg_addr;
  logic [DATA_W-1:0] id_ex_rd1;
  logic [DATA_W-1:0] id_ex_rd2;
  logic [DATA_W-1:0] id_ex_imm;
  logic              id_ex_reg_write;
  logic              id_ex_mem_read;
  logic              id_ex_mem_write;
  logic              id_ex_mem_to_reg;
  logic              id_ex_alu_src;
  logic [3:0]        id_ex_alu_op;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rd,
    output id_uses_rt, id_rd1, id_rd2, id_imm,
    output id_ctl_reg_write, id_ctl_mem_read,
    output id_ctl_mem_write, id_ctl_mem_to_reg,
    output id_ctl_alu_src, id_ctl_reg_dst,
    output id_ctl_alu_op,
    output wb_reg_write, wb_addr, wb_data,
    output flush, ex_stall,
    input  stall, id_ex_valid,
    input  id_ex_rs, id_ex_rt,
    input  id_ex_write_reg_addr,
    input  id_ex_rd1, id_ex_rd2, id_ex_imm,
    input  id_ex_reg_write, id_ex_mem_read,
    input  id_ex_mem_write, id_ex_mem_to_reg,
    input  id_ex_alu_src, id_ex_alu_op,
    input  bubble_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd,
    input  id_uses_rt, id_rd1, id_rd2, id_imm,
    input  id_ctl_reg_write, id_ctl_mem_read,
    input  id_ctl_mem_write, id_ctl_mem_to_reg,
    input  id_ctl_alu_src, id_ctl_reg_dst,
    input  id_ctl_alu_op,
    input  wb_reg_write, wb_addr, wb_data,
    input  flush, ex_stall,
    output stall, id_ex_valid,
    output id_ex_rs, id_ex_rt,
    output id_ex_write_reg_addr,
    output id_ex_rd1, id_ex_rd2, id_ex_imm,
    output id_ex_reg_write, id_ex_mem_read,
    output id_ex_mem_write, id_ex_mem_to_reg,
    output id_ex_alu_src, id_ex_alu_op,
    output bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard
// detection, WB bypass and saturating bubble count.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         rst_n,
  id_ex_stage_reg_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] wra;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              alu_src;
    logic [3:0]        alu_op;
  } id_ex_t;

  id_ex_t           q;
  id_ex_t           cap;
  logic [CNT_W-1:0] cnt;
  logic             hz;
  logic             byp1;
  logic             byp2;
  logic             wb_hit;

  // load in EX whose destination is read by the ID instruction
  always_comb begin
    hz = 1'b0;
    if (q.valid && q.mem_read && (q.wra != '0)
        && bus.id_valid) begin
      hz = (q.wra == bus.id_rs)
         | (bus.id_uses_rt & (q.wra == bus.id_rt));
    end
  end

  assign bus.stall = rst_n & ~bus.flush
                   & (bus.ex_stall | hz);

  assign wb_hit = bus.wb_reg_write
                & (bus.wb_addr != '0);
  assign byp1 = wb_hit & (bus.wb_addr == bus.id_rs);
  assign byp2 = wb_hit & (bus.wb_addr == bus.id_rt);

  // next-capture bundle from ID with WB bypass applied
  always_comb begin
    cap            = '0;
    cap.valid      = bus.id_valid;
    cap.rs         = bus.id_rs;
    cap.rt         = bus.id_rt;
    cap.wra        = bus.id_ctl_reg_dst ? bus.id_rd
                                        : bus.id_rt;
    cap.rd1        = byp1 ? bus.wb_data : bus.id_rd1;
    cap.rd2        = byp2 ? bus.wb_data : bus.id_rd2;
    cap.imm        = bus.id_imm;
    cap.reg_write  = bus.id_ctl_reg_write;
    cap.mem_read   = bus.id_ctl_mem_read;
    cap.mem_write  = bus.id_ctl_mem_write;
    cap.mem_to_reg = bus.id_ctl_mem_to_reg;
    cap.alu_src    = bus.id_ctl_alu_src;
    cap.alu_op     = bus.id_ctl_alu_op;
  end

  // flush > hold > hazard bubble > capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      cnt <= '0;
    end else if (bus.flush) begin
      q <= '0;
    end else if (bus.ex_stall) begin
      q <= q;
    end else if (hz) begin
      q <= '0;
      if (cnt != '1) cnt <= cnt + CNT_W'(1);
    end else begin
      q <= cap;
    end
  end

  assign bus.id_ex_valid          = q.valid;
  assign bus.id_ex_rs             = q.rs;
  assign bus.id_ex_rt             = q.rt;
  assign bus.id_ex_write_reg_addr = q.wra;
  assign bus.id_ex_rd1            = q.rd1;
  assign bus.id_ex_rd2            = q.rd2;
  assign bus.id_ex_imm            = q.imm;
  assign bus.id_ex_reg_write      = q.reg_write;
  assign bus.id_ex_mem_read       = q.mem_read;
  assign bus.id_ex_mem_write      = q.mem_write;
  assign bus.id_ex_mem_to_reg     = q.mem_to_reg;
  assign bus.id_ex_alu_src        = q.alu_src;
  assign bus.id_ex_alu_op         = q.alu_op;
  assign bus.bubble_cnt           = cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg; narrow bubble
// counter so saturation is reachable quickly.
module tb_id_ex_stage_reg;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg_if #(
    .DATA_W(DW), .REG_AW(AW), .CNT_W(CW)
  ) bus ();

  id_ex_stage_reg #(
    .DATA_W(DW), .REG_AW(AW), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic chk(
    input string tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(
    input logic v,
    input logic [AW-1:0] rs, rt, rd,
    input logic rdst, urt, mr,
    input logic [DW-1:0] r1, r2
  );
    bus.id_valid          = v;
    bus.id_rs             = rs;
    bus.id_rt             = rt;
    bus.id_rd             = rd;
    bus.id_ctl_reg_dst    = rdst;
    bus.id_uses_rt        = urt;
    bus.id_ctl_mem_read   = mr;
    bus.id_ctl_mem_to_reg = mr;
    bus.id_ctl_alu_src    = mr;
    bus.id_ctl_mem_write  = 1'b0;
    bus.id_ctl_reg_write  = 1'b1;
    bus.id_ctl_alu_op     = mr ? 4'h0 : 4'h2;
    bus.id_rd1            = r1;
    bus.id_rd2            = r2;
    bus.id_imm            = r1 ^ r2;
  endtask

  initial begin
    bus.id_valid          = 1'($urandom);
    bus.id_rs             = AW'($urandom);
    bus.id_rt             = AW'($urandom);
    bus.id_rd             = AW'($urandom);
    bus.id_uses_rt        = 1'($urandom);
    bus.id_rd1            = $urandom;
    bus.id_rd2            = $urandom;
    bus.id_imm            = $urandom;
    bus.id_ctl_reg_write  = 1'($urandom);
    bus.id_ctl_mem_read   = 1'($urandom);
    bus.id_ctl_mem_write  = 1'($urandom);
    bus.id_ctl_mem_to_reg = 1'($urandom);
    bus.id_ctl_alu_src    = 1'($urandom);
    bus.id_ctl_reg_dst    = 1'($urandom);
    bus.id_ctl_alu_op     = 4'($urandom);
    bus.wb_reg_write      = 1'($urandom);
    bus.wb_addr           = AW'($urandom);
    bus.wb_data           = $urandom;
    bus.flush             = 1'b0;
    bus.ex_stall          = 1'b1;
    step();
    step();
    chk("rst_valid", 64'(bus.id_ex_valid), 0);
    chk("rst_rd1", 64'(bus.id_ex_rd1), 0);
    chk("rst_imm", 64'(bus.id_ex_imm), 0);
    chk("rst_wra", 64'(bus.id_ex_write_reg_addr), 0);
    chk("rst_memrd", 64'(bus.id_ex_mem_read), 0);
    chk("rst_cnt", 64'(bus.bubble_cnt), 0);
    chk("rst_stall", 64'(bus.stall), 0);

    rst_n = 1'b1;
    bus.ex_stall = 1'b0;
    bus.wb_reg_write = 1'b0;
    instr(1, 3, 4, 9, 1, 1, 0, 32'h1111_1111, 32'h2222_2222);
    step();
    chk("cap_valid", 64'(bus.id_ex_valid), 1);
    chk("cap_rs", 64'(bus.id_ex_rs), 3);
    chk("cap_rt", 64'(bus.id_ex_rt), 4);
    chk("cap_wra", 64'(bus.id_ex_write_reg_addr), 9);
    chk("cap_rd1", 64'(bus.id_ex_rd1), 64'h1111_1111);
    chk("cap_rd2", 64'(bus.id_ex_rd2), 64'h2222_2222);
    chk("cap_imm", 64'(bus.id_ex_imm), 64'h3333_3333);
    chk("cap_aluop", 64'(bus.id_ex_alu_op), 2);

    // lw $8 then add $10,$8,$2
    instr(1, 1, 8, 0, 0, 0, 1, 32'h10, 32'h0);
    step();
    chk("lw_memrd", 64'(bus.id_ex_mem_read), 1);
    chk("lw_wra", 64'(bus.id_ex_write_reg_addr), 8);
    instr(1, 8, 2, 10, 1, 1, 0, 32'h5, 32'h6);
    #1;
    chk("lu_stall", 64'(bus.stall), 1);
    step();
    chk("bub_valid", 64'(bus.id_ex_valid), 0);
    chk("bub_rs", 64'(bus.id_ex_rs), 0);
    chk("bub_rt", 64'(bus.id_ex_rt), 0);
    chk("bub_wra", 64'(bus.id_ex_write_reg_addr), 0);
    chk("bub_regwr", 64'(bus.id_ex_reg_write), 0);
    chk("bub_cnt", 64'(bus.bubble_cnt), 1);
    chk("bub_stall", 64'(bus.stall), 0);
    step();
    chk("add_valid", 64'(bus.id_ex_valid), 1);
    chk("add_rs", 64'(bus.id_ex_rs), 8);
    chk("add_wra", 64'(bus.id_ex_write_reg_addr), 10);

    // lw $0 then reader of $0: no hazard
    instr(1, 1, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    step();
    instr(1, 0, 0, 11, 1, 1, 0, 32'h0, 32'h0);
    #1;
    chk("lw0_stall", 64'(bus.stall), 0);
    step();
    chk("lw0_valid", 64'(bus.id_ex_valid), 1);
    chk("lw0_cnt", 64'(bus.bubble_cnt), 1);

    // lw $8 then I-type writing rt=8, not reading it
    instr(1, 1, 8, 0, 0, 0, 1, 32'h0, 32'h0);
    step();
    instr(1, 3, 8, 0, 0, 0, 0, 32'h7, 32'h0);
    #1;
    chk("ityp_stall", 64'(bus.stall), 0);
    step();
    chk("ityp_rt", 64'(bus.id_ex_rt), 8);
    chk("ityp_cnt", 64'(bus.bubble_cnt), 1);

    // WB bypass on both operands
    bus.wb_reg_write = 1'b1;
    bus.wb_addr = 5;
    bus.wb_data = 32'hDEAD_BEEF;
    instr(1, 5, 5, 12, 1, 1, 0, 32'h0, 32'h1234);
    step();
    chk("byp_rd1", 64'(bus.id_ex_rd1), 64'hDEAD_BEEF);
    chk("byp_rd2", 64'(bus.id_ex_rd2), 64'hDEAD_BEEF);
    bus.wb_addr = 0;
    instr(1, 0, 0, 12, 1, 1, 0, 32'hA5A5, 32'h5A5A);
    step();
    chk("nbyp_rd1", 64'(bus.id_ex_rd1), 64'hA5A5);
    chk("nbyp_rd2", 64'(bus.id_ex_rd2), 64'h5A5A);
    bus.wb_addr = 5;
    instr(1, 5, 6, 12, 1, 1, 0, 32'h77, 32'h88);
    step();
    chk("byp1_rd1", 64'(bus.id_ex_rd1), 64'hDEAD_BEEF);
    chk("byp1_rd2", 64'(bus.id_ex_rd2), 64'h88);
    bus.wb_reg_write = 1'b0;

    // flush beats ex_stall and hazard
    instr(1, 1, 8, 0, 0, 0, 1, 32'h0, 32'h0);
    step();
    instr(1, 8, 2, 10, 1, 1, 0, 32'h5, 32'h6);
    bus.flush = 1'b1;
    bus.ex_stall = 1'b1;
    #1;
    chk("fl_stall", 64'(bus.stall), 0);
    step();
    chk("fl_valid", 64'(bus.id_ex_valid), 0);
    chk("fl_memrd", 64'(bus.id_ex_mem_read), 0);
    chk("fl_cnt", 64'(bus.bubble_cnt), 1);
    bus.flush = 1'b0;
    bus.ex_stall = 1'b0;

    // ex_stall alone holds contents
    instr(1, 6, 7, 13, 1, 1, 0, 32'hCAFE, 32'hF00D);
    step();
    instr(1, 9, 9, 14, 1, 1, 0, 32'h1, 32'h2);
    bus.ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_stall", 64'(bus.stall), 1);
      step();
      chk("hold_rs", 64'(bus.id_ex_rs), 6);
      chk("hold_rd1", 64'(bus.id_ex_rd1), 64'hCAFE);
    end
    bus.ex_stall = 1'b0;
    step();
    chk("rel_rs", 64'(bus.id_ex_rs), 9);

    // saturation with a 4-bit counter
    for (int i = 0; i < 19; i++) begin
      instr(1, 1, 8, 0, 0, 0, 1, 32'h0, 32'h0);
      step();
      instr(1, 8, 2, 10, 1, 1, 0, 32'h5, 32'h6);
      step();
      if (i == 9)
        chk("cnt_mid", 64'(bus.bubble_cnt), 11);
    end
    chk("cnt_sat", 64'(bus.bubble_cnt), 15);

    // async reset in the middle of a stall
    instr(1, 1, 8, 0, 0, 0, 1, 32'h0, 32'h0);
    step();
    instr(1, 8, 2, 10, 1, 1, 0, 32'h5, 32'h6);
    bus.ex_stall = 1'b1;
    #2;
    chk("pre_stall", 64'(bus.stall), 1);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(bus.id_ex_valid), 0);
    chk("ar_memrd", 64'(bus.id_ex_mem_read), 0);
    chk("ar_wra", 64'(bus.id_ex_write_reg_addr), 0);
    chk("ar_cnt", 64'(bus.bubble_cnt), 0);
    chk("ar_stall", 64'(bus.stall), 0);
    step();
    rst_n = 1'b1;
    bus.ex_stall = 1'b0;
    step();
    chk("post_rs", 64'(bus.id_ex_rs), 8);
    chk("post_cnt", 64'(bus.bubble_cnt), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
